mdu_div_issue: RTL
==================

MDU_DIV_ISSUE -- requirements
Module: mdu_div_issue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width (RV32M).
REQ-002 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port i_rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_flush  in  1  pipeline flush; aborts the in-flight op.
REQ-005 SHALL have port i_valid  in  1  EX-stage divide request, held stable until o_valid.
REQ-006 SHALL have port i_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports i_rs1, i_rs2  in  WIDTH  dividend, divisor.
REQ-008 SHALL have port o_stall  out  1  holds the pipeline.
REQ-009 SHALL have ports o_valid  out  1 and o_result  out  WIDTH  completed result.
REQ-010 SHALL have divider-side outputs o_div_start, o_div_flush, o_div_signed (1 each) and o_div_dividend, o_div_divisor (WIDTH each).
REQ-011 SHALL have divider-side inputs i_div_busy, i_div_end_valid (1 each) and i_div_quotient, i_div_remainder (WIDTH each).

Function
REQ-012 SHALL implement FSM states IDLE, START, WAIT, DONE.
REQ-013 IDLE + i_valid + special case or cache hit -> DONE with o_result registered; the divider is never started.
REQ-014 IDLE + i_valid otherwise -> START, latching rs1, rs2 and signed = ~i_funct3[0] into the operand registers.
REQ-015 START -> o_div_start=1 for exactly one cycle, o_div_* operands driven from the operand registers -> WAIT.
REQ-016 WAIT + i_div_end_valid -> capture i_div_quotient/i_div_remainder into result and cache -> DONE; otherwise stay in WAIT.
REQ-017 DONE -> o_valid=1 for exactly one cycle -> IDLE; a new request is accepted no earlier than the next cycle.
REQ-018 o_result SHALL be the quotient for funct3[1]=0 and the remainder for funct3[1]=1.
REQ-019 Divisor zero SHALL give quotient all-ones and remainder rs1, for both signed and unsigned.
REQ-020 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-021 Cache SHALL hold rs1, rs2, signed, quotient, remainder and a valid bit; it is written only on REQ-016 completion.
REQ-022 Cache hit SHALL be valid & equal rs1, rs2 and signed; serves DIV→REM (or reverse) pairs in one cycle.
REQ-023 o_stall = i_valid & ~o_valid, combinational.
REQ-024 Latency: fast path, request cycle T -> o_valid at T+1; divider path, o_valid one cycle after the i_div_end_valid capture.
REQ-025 i_flush in any state SHALL force IDLE next cycle, and o_valid SHALL be gated low in that cycle.
REQ-026 o_div_flush = i_flush & (state==START | state==WAIT).
REQ-027 A flushed op SHALL NOT update the cache.
REQ-028 i_flush has priority over i_div_end_valid arriving in the same cycle: result discarded, IDLE next.
REQ-029 i_div_end_valid outside WAIT SHALL be ignored.
REQ-030 i_div_busy is informational only; START SHALL be entered only when the divider is idle, and a sticky error flag is not required.
REQ-031 Opcodes with i_funct3[2]=0 SHALL be treated as no request; i_valid is ignored.

Reset
REQ-032 i_rst=0 at a clock edge SHALL set state IDLE, cache valid 0, and operand/result registers 0.
REQ-033 During reset o_valid, o_stall-internal state, o_div_start and o_div_flush SHALL be 0; o_result SHALL be 0.
REQ-034 Reset SHALL take priority over i_flush and over all FSM transitions, including mid-operation.

Verification
REQ-035 DIVU 100/7 via divider model (end_valid after 32 cycles) -> one o_div_start pulse, o_stall high until o_valid, o_result=14.
REQ-036 DIV rs1=0x80000000, rs2=0xFFFFFFFF -> o_valid at T+1, o_result=0x80000000, o_div_start never asserted.
REQ-037 REMU 5/0 -> o_result=5 at T+1; DIV 5/0 -> o_result=0xFFFFFFFF.
REQ-038 DIV -7/2 then REM -7/2 with the same operands -> first result 0xFFFFFFFD through the divider; second result 0xFFFFFFFF at T+1 from the cache, no start.
REQ-039 i_flush during WAIT, with i_div_end_valid in the same cycle -> o_div_flush=1, no o_valid, IDLE next, cache unchanged (a following REM re-runs the divider).
REQ-040 i_rst low mid-WAIT -> IDLE, o_valid 0, cache invalid; a subsequent request behaves as it does after power-up.

Source files
------------

// File: rtl/mdu_div_issue.sv
// Issue/control stage for an external multi-cycle divider (RV32M DIV/DIVU/REM/REMU).
// Special cases and repeated operand pairs complete in one cycle without starting the divider.
module mdu_div_issue #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_rs1,
  input  logic [WIDTH-1:0] i_rs2,
  output logic             o_stall,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div_start,
  output logic             o_div_flush,
  output logic             o_div_signed,
  output logic [WIDTH-1:0] o_div_dividend,
  output logic [WIDTH-1:0] o_div_divisor,
  input  logic             i_div_busy,
  input  logic             i_div_end_valid,
  input  logic [WIDTH-1:0] i_div_quotient,
  input  logic [WIDTH-1:0] i_div_remainder
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] rs1_reg, rs2_reg, result_reg;
  logic             signed_reg, rem_reg;
  logic             cache_valid_reg, cache_signed_reg;
  logic [WIDTH-1:0] cache_rs1_reg, cache_rs2_reg, cache_quot_reg, cache_rem_reg;

  logic             request, req_signed, req_rem;
  logic             div_zero, overflow, cache_hit;
  logic [WIDTH-1:0] fast_result;
  logic             load_ops, fast_load, capture;

  assign request    = i_valid & i_funct3[2];
  assign req_signed = ~i_funct3[0];
  assign req_rem    = i_funct3[1];
  assign div_zero   = (i_rs2 == '0);
  assign overflow   = req_signed & (i_rs1 == INT_MIN) & (i_rs2 == '1);
  assign cache_hit  = cache_valid_reg & (i_rs1 == cache_rs1_reg) &
                      (i_rs2 == cache_rs2_reg) & (req_signed == cache_signed_reg);

  always_comb begin
    fast_result = req_rem ? cache_rem_reg : cache_quot_reg;
    if (div_zero) begin
      fast_result = req_rem ? i_rs1 : '1;
    end else if (overflow) begin
      fast_result = req_rem ? '0 : INT_MIN;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_ops   = 1'b0;
    fast_load  = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (request) begin
          if (div_zero | overflow | cache_hit) begin
            state_next = DONE;
            fast_load  = 1'b1;
          end else if (!i_div_busy) begin
            state_next = START;
            load_ops   = 1'b1;
          end
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (i_div_end_valid) begin
          state_next = DONE;
          capture    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A flush kills whatever is in flight, including a result arriving this cycle.
    if (i_flush) begin
      state_next = IDLE;
      load_ops   = 1'b0;
      fast_load  = 1'b0;
      capture    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rs1_reg          <= '0;
      rs2_reg          <= '0;
      signed_reg       <= 1'b0;
      rem_reg          <= 1'b0;
      result_reg       <= '0;
      cache_valid_reg  <= 1'b0;
      cache_signed_reg <= 1'b0;
      cache_rs1_reg    <= '0;
      cache_rs2_reg    <= '0;
      cache_quot_reg   <= '0;
      cache_rem_reg    <= '0;
    end else begin
      if (load_ops) begin
        rs1_reg    <= i_rs1;
        rs2_reg    <= i_rs2;
        signed_reg <= req_signed;
        rem_reg    <= req_rem;
      end
      if (fast_load) begin
        result_reg <= fast_result;
      end
      if (capture) begin
        result_reg       <= rem_reg ? i_div_remainder : i_div_quotient;
        cache_valid_reg  <= 1'b1;
        cache_signed_reg <= signed_reg;
        cache_rs1_reg    <= rs1_reg;
        cache_rs2_reg    <= rs2_reg;
        cache_quot_reg   <= i_div_quotient;
        cache_rem_reg    <= i_div_remainder;
      end
    end
  end

  assign o_valid        = (state_reg == DONE) & ~i_flush;
  assign o_stall        = request & ~o_valid;
  assign o_result       = result_reg;
  assign o_div_start    = (state_reg == START);
  assign o_div_flush    = i_flush & ((state_reg == START) | (state_reg == WAIT));
  assign o_div_signed   = signed_reg;
  assign o_div_dividend = rs1_reg;
  assign o_div_divisor  = rs2_reg;

endmodule
